// File: rtl/picosoc_uart_fifo.sv
// Memory-mapped UART with TX/RX byte FIFOs, a programmable bit divider and a level interrupt.
// One clock domain; ser_rx is brought in through a two-flop synchroniser.
module picosoc_uart_fifo #(
    parameter int FIFO_DEPTH  = 16,
    parameter int DEFAULT_DIV = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_valid,
    output logic        reg_ready,
    input  logic [3:0]  reg_wstrb,
    input  logic [3:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        irq,
    output logic        ser_tx,
    input  logic        ser_rx
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    localparam logic [1:0] SEL_CLKDIV = 2'd0;
    localparam logic [1:0] SEL_DATA   = 2'd1;
    localparam logic [1:0] SEL_STATUS = 2'd2;
    localparam logic [1:0] SEL_IRQEN  = 2'd3;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_BREAK = 3'd4;

    logic [31:0]   clkdiv;
    logic [31:0]   eff_div;
    logic [1:0]    irqen;
    logic          overrun;
    logic          frame_err;

    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wptr, tx_rptr;
    logic [CW-1:0] tx_count;
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wptr, rx_rptr;
    logic [CW-1:0] rx_count;

    logic [1:0]    tx_state;
    logic [31:0]   tx_cnt, tx_div;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_bit_end;

    logic          rx_sync_p0, rx_sync_p1;
    logic          rx_in;
    logic [2:0]    rx_state;
    logic [31:0]   rx_cnt, rx_div;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_bit_end, rx_stop_done;

    logic [1:0]    reg_sel;
    logic          is_write;
    logic          tx_full, rx_full, rx_empty;
    logic          tx_push_req, bus_stall, bus_accept;
    logic          tx_push, tx_pop, rx_push, rx_pop;
    logic          overrun_set, frame_set, status_wr;
    logic [31:0]   rd_val;
    logic          unused_addr;

    function automatic logic [7:0] sat8(input logic [31:0] c);
        sat8 = (c > 32'd255) ? 8'hFF : c[7:0];
    endfunction

    assign unused_addr = &{1'b0, reg_addr[1:0]};
    assign eff_div     = (clkdiv < 32'd4) ? 32'd4 : clkdiv;

    assign reg_sel     = reg_addr[3:2];
    assign is_write    = |reg_wstrb;
    assign tx_full     = (tx_count == FIFO_FULL);
    assign rx_full     = (rx_count == FIFO_FULL);
    assign rx_empty    = (rx_count == '0);

    // A DATA write into a full TX FIFO is held off until the TX FSM frees a slot.
    assign tx_push_req = (reg_sel == SEL_DATA) && reg_wstrb[0];
    assign bus_stall   = tx_push_req && tx_full;
    assign bus_accept  = reg_valid && !reg_ready && !bus_stall;
    assign tx_push     = bus_accept && tx_push_req;
    assign rx_pop      = bus_accept && !is_write && (reg_sel == SEL_DATA) && !rx_empty;
    assign status_wr   = bus_accept && (reg_sel == SEL_STATUS) && reg_wstrb[0];

    assign tx_bit_end  = (tx_cnt == tx_div - 32'd1);
    assign tx_pop      = (tx_count != '0) &&
                         ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_bit_end));

    assign rx_in        = rx_sync_p1;
    assign rx_bit_end   = (rx_cnt == rx_div - 32'd1);
    assign rx_stop_done = (rx_state == RX_STOP) && rx_bit_end;
    assign rx_push      = rx_stop_done && rx_in && !rx_full;
    assign overrun_set  = rx_stop_done && rx_in && rx_full;
    assign frame_set    = rx_stop_done && !rx_in;

    assign irq = (irqen[0] && !rx_empty) ||
                 (irqen[1] && (tx_count == '0) && (tx_state == TX_IDLE));

    always_comb begin
        rd_val = 32'h0;
        case (reg_sel)
            SEL_CLKDIV: rd_val = clkdiv;
            SEL_DATA:   rd_val = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_mem[rx_rptr]};
            SEL_STATUS: rd_val = {8'h0, sat8(32'(tx_count)), sat8(32'(rx_count)), 4'h0,
                                  frame_err, overrun, rx_empty, tx_full};
            default:    rd_val = {30'h0, irqen};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_ready <= 1'b0;
            reg_rdata <= 32'h0;
            clkdiv    <= 32'(DEFAULT_DIV);
            irqen     <= 2'b00;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            reg_ready <= bus_accept;
            reg_rdata <= (bus_accept && !is_write) ? rd_val : 32'h0;
            if (bus_accept && is_write && reg_sel == SEL_CLKDIV) begin
                for (int i = 0; i < 4; i++)
                    if (reg_wstrb[i]) clkdiv[8*i +: 8] <= reg_wdata[8*i +: 8];
            end
            if (bus_accept && reg_sel == SEL_IRQEN && reg_wstrb[0])
                irqen <= reg_wdata[1:0];
            // A new event in the same cycle as a clear wins, so it is never lost.
            overrun   <= (overrun   && !(status_wr && reg_wdata[2])) || overrun_set;
            frame_err <= (frame_err && !(status_wr && reg_wdata[3])) || frame_set;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr] <= reg_wdata[7:0];
        if (rx_push) rx_mem[rx_wptr] <= rx_shift;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + AW'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + AW'(1);
            tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
            if (rx_push) rx_wptr <= rx_wptr + AW'(1);
            if (rx_pop)  rx_rptr <= rx_rptr + AW'(1);
            rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
        end
    end

    // The divider is captured on frame start so a CLKDIV write never stretches a frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            ser_tx   <= 1'b1;
            tx_cnt   <= 32'd0;
            tx_div   <= 32'd4;
            tx_bit   <= 3'd0;
            tx_shift <= 8'h0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_state <= TX_START;
                        ser_tx   <= 1'b0;
                        tx_shift <= tx_mem[tx_rptr];
                        tx_div   <= eff_div;
                        tx_cnt   <= 32'd0;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_cnt   <= 32'd0;
                        tx_bit   <= 3'd0;
                        tx_state <= TX_DATA;
                        ser_tx   <= tx_shift[0];
                    end else tx_cnt <= tx_cnt + 32'd1;
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt <= 32'd0;
                        if (tx_bit == 3'd7) begin
                            tx_state <= TX_STOP;
                            ser_tx   <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            ser_tx   <= tx_shift[1];
                            tx_shift <= tx_shift >> 1;
                        end
                    end else tx_cnt <= tx_cnt + 32'd1;
                end
                default: begin
                    if (tx_bit_end) begin
                        tx_cnt <= 32'd0;
                        if (tx_pop) begin
                            tx_state <= TX_START;
                            ser_tx   <= 1'b0;
                            tx_shift <= tx_mem[tx_rptr];
                            tx_div   <= eff_div;
                        end else tx_state <= TX_IDLE;
                    end else tx_cnt <= tx_cnt + 32'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= 32'd0;
            rx_div     <= 32'd4;
            rx_bit     <= 3'd0;
            rx_shift   <= 8'h0;
        end else begin
            rx_sync_p0 <= ser_rx;
            rx_sync_p1 <= rx_sync_p0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_in) begin
                        rx_state <= RX_START;
                        rx_cnt   <= 32'd0;
                        rx_div   <= eff_div;
                    end
                end
                RX_START: begin
                    // Mid-start resample rejects short glitches.
                    if (rx_cnt == (rx_div >> 1) - 32'd1) begin
                        rx_cnt   <= 32'd0;
                        rx_bit   <= 3'd0;
                        rx_state <= rx_in ? RX_IDLE : RX_DATA;
                    end else rx_cnt <= rx_cnt + 32'd1;
                end
                RX_DATA: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= 32'd0;
                        rx_shift <= {rx_in, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else rx_bit <= rx_bit + 3'd1;
                    end else rx_cnt <= rx_cnt + 32'd1;
                end
                RX_STOP: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= 32'd0;
                        rx_state <= rx_in ? RX_IDLE : RX_BREAK;
                    end else rx_cnt <= rx_cnt + 32'd1;
                end
                default: begin
                    if (rx_in) rx_state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_picosoc_uart_fifo.sv
// Directed bench for picosoc_uart_fifo: register access, TX framing, FIFO stall, loopback,
// RX error handling, interrupts and asynchronous reset.
`timescale 1ns/1ps
module tb_picosoc_uart_fifo;
    localparam int DEPTH = 16;
    localparam logic [3:0] A_CLKDIV = 4'h0;
    localparam logic [3:0] A_DATA   = 4'h4;
    localparam logic [3:0] A_STATUS = 4'h8;
    localparam logic [3:0] A_IRQEN  = 4'hC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reg_valid = 1'b0;
    logic        reg_ready;
    logic [3:0]  reg_wstrb = 4'h0;
    logic [3:0]  reg_addr = 4'h0;
    logic [31:0] reg_wdata = 32'h0;
    logic [31:0] reg_rdata;
    logic        irq, ser_tx, ser_rx;
    logic        rx_drv = 1'b1;
    logic        loop_en = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    assign ser_rx = loop_en ? ser_tx : rx_drv;

    picosoc_uart_fifo #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16)) dut (
        .clk(clk), .reset(reset), .reg_valid(reg_valid), .reg_ready(reg_ready),
        .reg_wstrb(reg_wstrb), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .irq(irq), .ser_tx(ser_tx), .ser_rx(ser_rx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reg_valid = 1'b0; reg_wstrb = 4'h0; rx_drv = 1'b1; loop_en = 1'b0;
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic bus_xfer(input logic [3:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                            output logic [31:0] rdata, output int waited);
        logic done;
        @(negedge clk);
        reg_addr = addr; reg_wdata = wdata; reg_wstrb = strb; reg_valid = 1'b1;
        waited = 0; rdata = 32'h0; done = 1'b0;
        while (!done) begin
            @(posedge clk); #1;
            waited++;
            if (reg_ready === 1'b1) begin
                rdata = reg_rdata; done = 1'b1;
            end else if (waited > 3000) begin
                checks++; errors++;
                $display("FAIL bus_timeout addr=%h: no reg_ready after %0d cycles, expected completion", addr, waited);
                done = 1'b1;
            end
        end
        reg_valid = 1'b0; reg_wstrb = 4'h0;
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
        logic [31:0] d; int w;
        bus_xfer(addr, wdata, strb, d, w);
    endtask

    task automatic bus_read(input logic [3:0] addr, output logic [31:0] d);
        int w;
        bus_xfer(addr, 32'h0, 4'h0, d, w);
    endtask

    task automatic wait_tx_low(output logic ok);
        int n;
        n = 0; ok = 1'b0;
        while (!ok && n < 400) begin
            @(negedge clk);
            if (ser_tx === 1'b0) ok = 1'b1;
            n++;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL tx_start_timeout: ser_tx=%b, expected a start bit", ser_tx);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int div);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); rx_drv = fr[i];
            repeat (div - 1) @(negedge clk);
        end
        @(negedge clk); rx_drv = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        checks++; if (ser_tx !== 1'b1 || reg_ready !== 1'b0 || reg_rdata !== 32'h0 || irq !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: tx=%b rdy=%b rdata=%h irq=%b, expected 1 0 0 0", ser_tx, reg_ready, reg_rdata, irq);
        end
        bus_read(A_CLKDIV, d);
        checks++; if (d !== 32'd16) begin errors++; $display("FAIL reset_clkdiv: got %h expected %h", d, 32'd16); end
        bus_read(A_STATUS, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL reset_status: got %h expected %h", d, 32'h2); end
        bus_read(A_IRQEN, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_irqen: got %h expected %h", d, 32'h0); end
        bus_read(A_DATA, d);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL empty_data_read: got %h expected ffffffff", d); end
    endtask

    task automatic test_clkdiv_strobes();
        logic [31:0] d;
        do_reset();
        bus_write(A_CLKDIV, 32'h1234_5678, 4'hF);
        bus_write(A_CLKDIV, 32'hAABB_CCDD, 4'b0100);
        bus_read(A_CLKDIV, d);
        checks++; if (d !== 32'h12BB_5678) begin errors++; $display("FAIL clkdiv_strobe: got %h expected 12bb5678", d); end
        @(posedge clk); #1;
        checks++; if (reg_ready !== 1'b0 || reg_rdata !== 32'h0) begin
            errors++; $display("FAIL rdata_idle: rdy=%b rdata=%h expected 0 00000000", reg_ready, reg_rdata);
        end
    endtask

    task automatic test_tx_frame(input logic [31:0] div_wr, input int eff, input logic [7:0] b);
        logic ok; logic [9:0] fr;
        do_reset();
        bus_write(A_IRQEN, 32'h2, 4'hF);
        bus_write(A_CLKDIV, div_wr, 4'hF);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_tx_idle: irq=%b expected 1", irq); end
        bus_write(A_DATA, {24'h0, b}, 4'h1);
        wait_tx_low(ok);
        if (ok) begin
            fr = {1'b1, b, 1'b0};
            for (int i = 0; i < 10 * eff; i++) begin
                if (i > 0) @(negedge clk);
                checks++; if (ser_tx !== fr[i / eff]) begin
                    errors++; $display("FAIL tx_bit byte=%h clk=%0d: ser_tx=%b expected %b", b, i, ser_tx, fr[i / eff]);
                end
            end
            checks++; if (irq !== 1'b0) begin errors++; $display("FAIL tx_last_clk: irq=%b expected 0", irq); end
            @(negedge clk);
            checks++; if (irq !== 1'b1 || ser_tx !== 1'b1) begin
                errors++; $display("FAIL tx_frame_end: irq=%b ser_tx=%b expected 1 1", irq, ser_tx);
            end
        end
    endtask

    task automatic test_data_no_push();
        logic [31:0] d; int lows;
        do_reset();
        bus_write(A_DATA, 32'h55, 4'b0010);
        lows = 0;
        repeat (30) begin @(negedge clk); if (ser_tx !== 1'b1) lows++; end
        checks++; if (lows != 0) begin errors++; $display("FAIL no_push_line: %0d low clocks, expected 0", lows); end
        bus_read(A_STATUS, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL no_push_status: got %h expected 00000002", d); end
    endtask

    task automatic test_back_to_back();
        logic ok; int s0;
        do_reset();
        bus_write(A_CLKDIV, 32'd8, 4'hF);
        bus_write(A_DATA, 32'h10, 4'h1);
        wait_tx_low(ok);
        s0 = cyc;
        if (ok) fork
            begin
                int w; logic [31:0] rd;
                for (int k = 0; k < DEPTH; k++) begin
                    bus_xfer(A_DATA, 32'h20 + k, 4'h1, rd, w);
                    checks++; if (w > 2) begin errors++; $display("FAIL tx_push_nostall k=%0d: waited %0d, expected <=2", k, w); end
                end
                bus_read(A_STATUS, rd);
                checks++; if (rd !== 32'h0010_0003) begin errors++; $display("FAIL tx_full_status: got %h expected 00100003", rd); end
                bus_xfer(A_DATA, 32'h20 + DEPTH, 4'h1, rd, w);
                checks++; if (w < 10) begin errors++; $display("FAIL tx_full_stall: waited %0d, expected >=10", w); end
            end
            begin
                logic ok2; logic [7:0] b, eb; int st;
                repeat (76) @(negedge clk);
                for (int k = 0; k <= DEPTH; k++) begin
                    wait_tx_low(ok2);
                    if (ok2) begin
                        st = cyc;
                        checks++; if (st != s0 + 80 * (k + 1)) begin
                            errors++; $display("FAIL tx_gap k=%0d: start at %0d expected %0d", k, st - s0, 80 * (k + 1));
                        end
                        repeat (4) @(negedge clk);
                        for (int j = 0; j < 8; j++) begin repeat (8) @(negedge clk); b[j] = ser_tx; end
                        repeat (8) @(negedge clk);
                        eb = 8'(32'h20 + k);
                        checks++; if (b !== eb || ser_tx !== 1'b1) begin
                            errors++; $display("FAIL tx_order k=%0d: byte=%h stop=%b expected %h 1", k, b, ser_tx, eb);
                        end
                    end
                end
            end
        join
    endtask

    task automatic test_loopback();
        logic [31:0] d;
        logic [31:0] exp_lb [4];
        exp_lb = '{32'h0, 32'hFF, 32'h3C, 32'hFFFF_FFFF};
        do_reset();
        loop_en = 1'b1;
        bus_write(A_CLKDIV, 32'd4, 4'hF);
        bus_write(A_DATA, 32'h00, 4'h1);
        bus_write(A_DATA, 32'hFF, 4'h1);
        bus_write(A_DATA, 32'h3C, 4'h1);
        repeat (160) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus_read(A_DATA, d);
            checks++; if (d !== exp_lb[i]) begin errors++; $display("FAIL loopback[%0d]: got %h expected %h", i, d, exp_lb[i]); end
        end
        loop_en = 1'b0;
    endtask

    task automatic test_rx_overrun();
        logic [31:0] d;
        do_reset();
        bus_write(A_CLKDIV, 32'd4, 4'hF);
        for (int k = 0; k <= DEPTH; k++) send_rx(8'(k + 1), 1'b1, 4);
        repeat (10) @(negedge clk);
        bus_read(A_STATUS, d);
        checks++; if (d !== 32'h0000_1004) begin errors++; $display("FAIL overrun_status: got %h expected 00001004", d); end
        bus_write(A_STATUS, 32'h4, 4'h1);
        bus_read(A_STATUS, d);
        checks++; if (d !== 32'h0000_1000) begin errors++; $display("FAIL overrun_clear: got %h expected 00001000", d); end
        bus_read(A_DATA, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL rx_first_byte: got %h expected 00000001", d); end
    endtask

    task automatic test_rx_errors();
        logic [31:0] d;
        do_reset();
        bus_write(A_CLKDIV, 32'd4, 4'hF);
        @(negedge clk); rx_drv = 1'b0;
        @(negedge clk); rx_drv = 1'b1;
        repeat (50) @(negedge clk);
        bus_read(A_STATUS, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL rx_glitch: status %h expected 00000002", d); end
        send_rx(8'h5A, 1'b0, 4);
        repeat (20) @(negedge clk);
        bus_read(A_STATUS, d);
        checks++; if (d !== 32'hA) begin errors++; $display("FAIL frame_err: status %h expected 0000000a", d); end
        bus_write(A_STATUS, 32'h8, 4'h1);
        send_rx(8'hC3, 1'b1, 4);
        repeat (10) @(negedge clk);
        bus_read(A_STATUS, d);
        checks++; if (d !== 32'h0000_0100) begin errors++; $display("FAIL frame_err_clear: status %h expected 00000100", d); end
        bus_read(A_DATA, d);
        checks++; if (d !== 32'hC3) begin errors++; $display("FAIL rx_after_break: got %h expected 000000c3", d); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        do_reset();
        bus_write(A_CLKDIV, 32'd4, 4'hF);
        bus_write(A_IRQEN, 32'h1, 4'h1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_empty: irq=%b expected 0", irq); end
        send_rx(8'h77, 1'b1, 4);
        repeat (5) @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rx: irq=%b expected 1", irq); end
        bus_read(A_DATA, d);
        checks++; if (d !== 32'h77 || irq !== 1'b0) begin
            errors++; $display("FAIL irq_after_pop: data=%h irq=%b expected 00000077 0", d, irq);
        end
    endtask

    task automatic test_reset_mid_tx();
        logic ok; logic [31:0] d;
        do_reset();
        bus_write(A_DATA, 32'h00, 4'h1);
        wait_tx_low(ok);
        repeat (20) @(negedge clk);
        checks++; if (ser_tx !== 1'b0) begin errors++; $display("FAIL tx_busy_before_reset: ser_tx=%b expected 0", ser_tx); end
        #2 reset = 1'b1;
        #1;
        checks++; if (ser_tx !== 1'b1) begin errors++; $display("FAIL tx_async_reset: ser_tx=%b expected 1", ser_tx); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        bus_read(A_STATUS, d);
        checks++; if (d !== 32'h2 || ser_tx !== 1'b1) begin
            errors++; $display("FAIL after_abort: status=%h ser_tx=%b expected 00000002 1", d, ser_tx);
        end
    endtask

    initial begin
        test_reset();
        test_clkdiv_strobes();
        test_tx_frame(32'd8, 8, 8'hA5);
        test_tx_frame(32'd2, 4, 8'h3C);
        test_data_no_push();
        test_back_to_back();
        test_loopback();
        test_rx_overrun();
        test_rx_errors();
        test_irq();
        test_reset_mid_tx();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/picosoc_uart_fifo.md
PICOSOC_UART_FIFO -- requirements
Module: picosoc_uart_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning TX and RX FIFO entries each; power of two, 2..256.
REQ-002 SHALL have parameter DEFAULT_DIV, default 16, meaning the clkdiv reset value in clocks per bit.
REQ-003 SHALL have port clk, input, 1 bit: sole clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port reg_valid, input, 1 bit: bus request, held until reg_ready.
REQ-006 SHALL have port reg_ready, output, 1 bit: single-cycle completion pulse.
REQ-007 SHALL have port reg_wstrb, input, 4 bits: byte write strobes; all zero means read.
REQ-008 SHALL have port reg_addr, input, 4 bits: word offset (bits 1:0 ignored).
REQ-009 SHALL have port reg_wdata, input, 32 bits: write data.
REQ-010 SHALL have port reg_rdata, output, 32 bits: read data, valid while reg_ready=1, otherwise 0.
REQ-011 SHALL have port irq, output, 1 bit: level interrupt.
REQ-012 SHALL have port ser_tx, output, 1 bit: serial out, idle high.
REQ-013 SHALL have port ser_rx, input, 1 bit: serial in, asynchronous to clk.

Function
REQ-014 SHALL decode four registers: 0x0 CLKDIV (32b RW, strobes per byte); 0x4 DATA; 0x8 STATUS; 0xC IRQEN (bits 1:0 RW).
REQ-015 SHALL assert reg_ready one cycle after reg_valid is sampled high, except a DATA write with TX FIFO full, which SHALL hold reg_ready low until a slot frees; then it pushes and completes.
REQ-016 SHALL push wdata[7:0] to TX FIFO on DATA write with reg_wstrb[0]=1; a DATA write with wstrb[0]=0 SHALL complete without a push.
REQ-017 SHALL pop RX FIFO on DATA read and return {24'h0, byte}; when empty it SHALL return 32'hFFFF_FFFF with no pop.
REQ-018 SHALL return STATUS = {8'h0, tx_count[7:0], rx_count[7:0], 4'h0, frame_err, overrun, rx_empty, tx_full}; counts saturate at 255 display.
REQ-019 SHALL clear overrun (bit2) and frame_err (bit3) on STATUS write with the matching wdata bit=1 (write-1-to-clear); other STATUS bits are read-only.
REQ-020 SHALL treat effective divider as max(CLKDIV, 4); every serial bit lasts exactly that many clocks.
REQ-021 SHALL run the TX FSM IDLE->START->DATA(8 bits, LSB first)->STOP->IDLE, driving 0, the data bits, then 1; it leaves IDLE the cycle after the FIFO is non-empty and pops on entry to START.
REQ-022 SHALL allow back-to-back TX frames with no idle gap between STOP and the next START.
REQ-023 SHALL synchronise ser_rx through two flops before use.
REQ-024 SHALL run the RX FSM IDLE->START->DATA->STOP: falling edge enters START; at div/2 the line is resampled and, if high, the FSM returns to IDLE (glitch); data and stop bits are sampled at centre, div clocks apart.
REQ-025 SHALL push the byte if the stop bit is high and the RX FIFO is not full; if full, it SHALL drop the byte and set overrun; if the stop bit is low, it SHALL drop the byte, set frame_err, and wait for line high before IDLE.
REQ-026 SHALL handle a simultaneous RX push and bus pop in the same cycle with both taking effect and the count unchanged.
REQ-027 SHALL apply a CLKDIV write only at the next frame start for frames in flight.
REQ-028 SHALL drive irq = (IRQEN[0] & !rx_empty) | (IRQEN[1] & tx_count==0 & TX FSM idle).

Reset
REQ-029 SHALL, on reset, empty both FIFOs, set CLKDIV=DEFAULT_DIV, IRQEN=0, both flags=0, both FSMs=IDLE, ser_tx=1, reg_ready=0, reg_rdata=0, and irq=0.
REQ-030 SHALL, on reset asserted mid-frame, abort the frame immediately with ser_tx=1 and no partial push.

Verification
REQ-031 SHALL verify: write CLKDIV=8, DATA=0xA5 -> ser_tx low 8 clocks, then bits 1,0,1,0,0,1,0,1 of 8 clocks each, then high; exactly 80 clocks.
REQ-032 SHALL verify: push FIFO_DEPTH+1 bytes with the line busy -> the last write stalls reg_ready until the first START pops, then completes; all bytes are sent in order with no gaps.
REQ-033 SHALL verify: loopback ser_tx->ser_rx, sending 0x00, 0xFF, 0x3C -> DATA reads return 0x00, 0xFF, 0x3C, then 0xFFFFFFFF.
REQ-034 SHALL verify: inject FIFO_DEPTH+1 frames without reads -> rx_count=FIFO_DEPTH, overrun=1; writing STATUS=0x4 clears overrun.
REQ-035 SHALL verify: a 1-clock low glitch on ser_rx -> no push; a low stop bit -> frame_err=1 and no push.
REQ-036 SHALL verify: IRQEN=1 with one RX byte -> irq=1; reading DATA -> irq=0 next cycle; reset asserted mid-TX -> ser_tx=1 asynchronously.
